// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner tag encoding and
// the default starvation limit.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port DMEM with 1-cycle read latency.
// CPU has priority; the debug port is forced through after STARVE_MAX lost contentions.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_we,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  owner,
    output logic [3:0]  starve_cnt
);

    // Handshake: a requester holds req and its addr/wdata/we stable until it
    // sees gnt in the same cycle; the access completes with a one-cycle
    // rvalid strobe on the following cycle. Dropping req before gnt withdraws it.

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_e     owner_q;
    owner_e     owner_d;
    logic       write_q;
    logic       write_d;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       dbg_due;

    assign dbg_due = dbg_req && (starve_q == STARVE_LIM);

    always_comb begin
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        owner_d  = OWNER_NONE;
        write_d  = 1'b0;
        starve_d = 4'd0;
        if (reset) begin
            if (cpu_req && !dbg_due) begin
                cpu_gnt = 1'b1;
                owner_d = OWNER_CPU;
                write_d = |cpu_we;
                // Only a lost contention counts toward starvation.
                if (dbg_req && (starve_q < STARVE_LIM)) begin
                    starve_d = starve_q + 4'd1;
                end
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
                owner_d = OWNER_DBG;
                write_d = |dbg_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q  <= OWNER_NONE;
            write_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            write_q  <= write_d;
            starve_q <= starve_d;
        end
    end

    // Idle cycles park the memory address/data on the CPU port.
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_we    = cpu_gnt ? cpu_we : (dbg_gnt ? dbg_we : 4'b0000);

    // Responses are squashed while reset is low so in-flight accesses are dropped.
    assign cpu_rvalid = reset && (owner_q == OWNER_CPU);
    assign dbg_rvalid = reset && (owner_q == OWNER_DBG);
    assign cpu_rdata  = (cpu_rvalid && !write_q) ? mem_rdata : 32'h0;
    assign dbg_rdata  = (dbg_rvalid && !write_q) ? mem_rdata : 32'h0;

    assign owner      = owner_q;
    assign starve_cnt = starve_q;

endmodule
